// File: rtl/click_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// click_pattern_gen_pkg
//   Shared definitions for the click pattern generator: FSM state encodings,
//   the press-count width, and a helper that converts a duration in cycles
//   into the value loaded into the down-counting cycle timer.
// -----------------------------------------------------------------------------
package click_pattern_gen_pkg;

  localparam int STATE_W  = 2;
  localparam int CLICKS_W = 3;

  typedef enum logic [STATE_W-1:0] {
    CLK_IDLE  = 2'd0,
    CLK_PRESS = 2'd1,
    CLK_GAP   = 2'd2,
    CLK_QUIET = 2'd3
  } click_state_e;

  // The timer counts down to zero and the state changes on the zero cycle.
  // A phase of N cycles therefore loads N-1.
  function automatic int timer_load(input int cycles);
    return cycles - 1;
  endfunction

endpackage

// File: rtl/click_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// click_pattern_gen_if
//   Request-side handshake for the click pattern generator.
//     req_valid   requester -> gen   request present
//     req_clicks  requester -> gen   presses to emit (0 = no-op)
//     abort       requester -> gen   synchronous abort of the current pattern
//     req_ready   gen -> requester   generator can accept a request
//   master: the control FSM / CPU register side.  slave: the generator.
// -----------------------------------------------------------------------------
interface click_pattern_gen_if;
  import click_pattern_gen_pkg::*;

  logic                req_valid;
  logic [CLICKS_W-1:0] req_clicks;
  logic                abort;
  logic                req_ready;

  modport master (
    output req_valid,
    output req_clicks,
    output abort,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_clicks,
    input  abort,
    output req_ready
  );

endinterface

// File: rtl/cycle_timer.sv
// -----------------------------------------------------------------------------
// cycle_timer
//   Down-counter shared by all timed FSM phases. A load pulse captures value;
//   afterwards the count decrements once per cycle and holds at zero.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     load       capture value this edge (wins over counting)
//     value      count to load (phase duration minus one)
//     zero       count has reached zero (phase's last cycle)
// -----------------------------------------------------------------------------
module cycle_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/click_pattern_gen.sv
// -----------------------------------------------------------------------------
// click_pattern_gen
//   Drives a button-like line with N clean press pulses (1..7) per request,
//   separated by gaps and followed by a quiet period long enough for the click
//   detector's window to close. Acts as the transmitter for the click detector.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     req          request handshake (slave side): req_valid, req_clicks,
//                  abort in; req_ready out
//     button_out   generated press waveform, registered, high only in PRESS
//     busy         pattern in progress (state != IDLE)
//     done         one-cycle pulse in the first IDLE cycle after a completed
//                  pattern (or the cycle after a zero-click request)
// -----------------------------------------------------------------------------
module click_pattern_gen
  import click_pattern_gen_pkg::*;
#(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 3,
  parameter int QUIET_CYCLES = 10,
  parameter int CNT_WIDTH    = 20
) (
  input  logic                clk,
  input  logic                rst,
  click_pattern_gen_if.slave  req,
  output logic                button_out,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_WIDTH-1:0] PRESS_LOAD = CNT_WIDTH'(timer_load(PRESS_CYCLES));
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD   = CNT_WIDTH'(timer_load(GAP_CYCLES));
  localparam logic [CNT_WIDTH-1:0] QUIET_LOAD = CNT_WIDTH'(timer_load(QUIET_CYCLES));

  click_state_e        state;
  click_state_e        state_next;
  logic [CLICKS_W-1:0] press_cnt;
  logic [CLICKS_W-1:0] press_cnt_next;
  logic                done_next;
  logic                timer_load_en;
  logic [CNT_WIDTH-1:0] timer_value;
  logic                timer_zero;
  logic                accept;

  // Abort wins over a pending request: ready drops in the abort cycle.
  assign req.req_ready = (state == CLK_IDLE) && !req.abort;
  assign accept        = req.req_valid && req.req_ready;
  assign busy          = (state != CLK_IDLE);

  cycle_timer #(
    .WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load_en),
    .value (timer_value),
    .zero  (timer_zero)
  );

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next     = state;
    press_cnt_next = press_cnt;
    done_next      = 1'b0;
    timer_load_en  = 1'b0;
    timer_value    = '0;

    if (req.abort) begin
      state_next     = CLK_IDLE;
      press_cnt_next = '0;
    end else begin
      unique case (state)
        CLK_IDLE: begin
          if (accept) begin
            if (req.req_clicks != '0) begin
              state_next     = CLK_PRESS;
              press_cnt_next = req.req_clicks;
              timer_load_en  = 1'b1;
              timer_value    = PRESS_LOAD;
            end else begin
              // Zero clicks: nothing to emit, acknowledge next cycle.
              done_next = 1'b1;
            end
          end
        end

        CLK_PRESS: begin
          if (timer_zero) begin
            press_cnt_next = press_cnt - CLICKS_W'(1);
            timer_load_en  = 1'b1;
            // press_cnt still counts the press ending now.
            if (press_cnt > CLICKS_W'(1)) begin
              state_next  = CLK_GAP;
              timer_value = GAP_LOAD;
            end else begin
              state_next  = CLK_QUIET;
              timer_value = QUIET_LOAD;
            end
          end
        end

        CLK_GAP: begin
          if (timer_zero) begin
            state_next    = CLK_PRESS;
            timer_load_en = 1'b1;
            timer_value   = PRESS_LOAD;
          end
        end

        CLK_QUIET: begin
          if (timer_zero) begin
            state_next = CLK_IDLE;
            done_next  = 1'b1;
          end
        end

        default: begin
          state_next = CLK_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLK_IDLE;
      press_cnt  <= '0;
      done       <= 1'b0;
      button_out <= 1'b0;
    end else begin
      state      <= state_next;
      press_cnt  <= press_cnt_next;
      done       <= done_next;
      // Registered from the next state so the line is glitch-free and
      // tracks PRESS exactly.
      button_out <= (state_next == CLK_PRESS);
    end
  end

endmodule

// File: tb/tb_click_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_click_pattern_gen
//   Directed bench for click_pattern_gen with PRESS=4, GAP=3, QUIET=10.
//   Cycle k is the clock period following edge k-1, with edge 0 the accept
//   edge; outputs are sampled at the falling edge in the middle of each cycle.
//   A rising-edge counter on button_out stands in for the click detector.
// -----------------------------------------------------------------------------
module tb_click_pattern_gen;

  localparam int P = 4;
  localparam int G = 3;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst;
  logic button_out;
  logic busy;
  logic done;

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0;
  int rises_base = 0;

  click_pattern_gen_if bus ();

  click_pattern_gen #(
    .PRESS_CYCLES (P),
    .GAP_CYCLES   (G),
    .QUIET_CYCLES (Q),
    .CNT_WIDTH    (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus),
    .button_out (button_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Loopback "detector": counts presses seen on the line.
  always @(posedge button_out) rises = rises + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dur(input int n);
    return (n == 0) ? 1 : 1 + n*P + (n-1)*G + Q;
  endfunction

  // Expected {button_out, busy, req_ready, done} in cycle k of an n-click pattern.
  function automatic logic [3:0] exp_vec(input int n, input int k);
    int   t;
    logic b;
    t = k - 1;
    b = (n > 0) && (t < n*P + (n-1)*G) && ((t % (P+G)) < P);
    if (k >= dur(n)) return {1'b0, 1'b0, 1'b1, (k == dur(n))};
    return {b, 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic [3:0] obs();
    return {button_out, busy, bus.req_ready, done};
  endfunction

  // Present a request mid-cycle; returns right after the accept edge.
  task automatic issue(input int n);
    @(negedge clk);
    rises_base     = rises;
    bus.req_valid  = 1'b1;
    bus.req_clicks = 3'(n);
    @(posedge clk);
  endtask

  // Check every cycle of an accepted pattern through its done cycle. After
  // sampling cycle 1, req_clicks changes to next_clicks (must be ignored by the
  // running pattern) and req_valid drops unless held for a back-to-back request.
  task automatic expect_pattern(input int n, input int next_clicks, input bit drop);
    for (int k = 1; k <= dur(n); k++) begin
      @(negedge clk);
      check($sformatf("n%0d_cyc%0d", n, k), 32'(obs()), 32'(exp_vec(n, k)));
      if (k == 1) begin
        bus.req_clicks = 3'(next_clicks);
        if (drop) bus.req_valid = 1'b0;
      end
    end
    check($sformatf("loopback_n%0d", n), 32'(rises - rises_base), 32'(n));
    rises_base = rises;
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen = seen | done | busy | button_out;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_clicks = '0;
    bus.abort      = 1'b0;
    #1;
    check("reset_async", 32'(obs()), 32'b0010);
    repeat (2) @(negedge clk);
    check("reset_held", 32'(obs()), 32'b0010);
    rst = 1'b0;

    // Single, double, max and zero patterns.
    issue(1); expect_pattern(1, 6, 1'b1);
    issue(2); expect_pattern(2, 7, 1'b1);
    issue(7); expect_pattern(7, 0, 1'b1);
    issue(0); expect_pattern(0, 0, 1'b1);
    @(negedge clk);
    check("zero_done_one_cycle", 32'(obs()), 32'b0010);

    // Backpressure: valid held, re-accepted on the done edge with clicks=1.
    issue(2); expect_pattern(2, 1, 1'b0);
    expect_pattern(1, 0, 1'b1);
    @(negedge clk);
    check("b2b_idle_after", 32'(obs()), 32'b0010);

    // Abort during the second press of a 2-click pattern.
    issue(2);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("abort_pre_cyc%0d", k), 32'(obs()), 32'(exp_vec(2, k)));
      if (k == 1) bus.req_valid = 1'b0;
    end
    bus.abort = 1'b1;
    #1;
    check("abort_blocks_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_next_cycle", 32'(obs()), 32'b0010);
    watch_no_done("abort_no_done", 20);

    // Abort in IDLE wins over req_valid.
    @(negedge clk);
    bus.abort      = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_clicks = 3'd1;
    #1;
    check("abort_idle_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.abort     = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_idle_no_accept", 32'(obs()), 32'b0010);
    issue(1); expect_pattern(1, 0, 1'b1);

    // Async reset during GAP of a 2-click pattern.
    issue(2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("rstgap_pre_cyc%0d", k), 32'(obs()), 32'(exp_vec(2, k)));
      if (k == 1) bus.req_valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("rst_in_gap", 32'(obs()), 32'b0010);
    @(negedge clk);
    rst = 1'b0;
    watch_no_done("rst_gap_no_done", 20);

    // Async reset during PRESS: line drops without waiting for a clock edge.
    issue(1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rstpress_pre", 32'(button_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_in_press", 32'(obs()), 32'b0010);
    @(negedge clk);
    rst = 1'b0;
    watch_no_done("rst_press_no_done", 20);

    // Generator recovers fully after reset.
    issue(2); expect_pattern(2, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
